// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-stage controller with extension, sub-word read-modify-write and fault detection.
// Optional LSU_PERF_CNT_EN adds load/store/fault completion counters.
module load_store_unit #(
  parameter int MEM_BYTES = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        fault_o,
  output logic        stall_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_rdata_i
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0] load_cnt_o,
  output logic [31:0] store_cnt_o,
  output logic [31:0] fault_cnt_o
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, merged_q, merged_d, rdata_q, rdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        fault_q, fault_d;
  logic        illegal, misalign, oor, req_fault;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext, merged_w;
  assign illegal   = req_write_i ? (req_funct3_i > 3'b010)
                                 : (req_funct3_i == 3'b011 || req_funct3_i > 3'b101);
  assign misalign  = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                     (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
  assign oor       = ({1'b0, req_addr_i[31:2], 2'b00} + 33'd3) >= 33'(MEM_BYTES);
  assign req_fault = illegal | misalign | oor;
  assign ld_byte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
  assign ld_ext  = funct3_q[1] ? mem_rdata_i
                 : funct3_q[0] ? {{16{~funct3_q[2] & ld_half[15]}}, ld_half}
                 : {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
  // Store data sits in merged_q's low lanes until the old word arrives.
  always_comb begin
    merged_w = mem_rdata_i;
    if (funct3_q[0]) merged_w[{addr_q[1], 4'b0000} +: 16] = merged_q[15:0];
    else merged_w[{addr_q[1:0], 3'b000} +: 8] = merged_q[7:0];
  end
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    fault_d  = fault_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        addr_d   = req_addr_i;
        funct3_d = req_funct3_i;
        fault_d  = req_fault;
        merged_d = req_wdata_i;
        state_d  = req_fault ? RESP : !req_write_i ? LOAD : req_funct3_i[1] ? WRITE : RMW_RD;
      end
      LOAD: begin
        rdata_d = ld_ext;
        state_d = RESP;
      end
      RMW_RD: begin
        merged_d = merged_w;
        state_d  = WRITE;
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      fault_q  <= 1'b0;
      merged_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      fault_q  <= fault_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
    end
  end
  assign req_ready_o  = state_q == IDLE;
  assign stall_o      = state_q != IDLE || req_valid_i;
  assign resp_valid_o = state_q == RESP;
  assign fault_o      = state_q == RESP && fault_q;
  assign resp_rdata_o = rdata_q;
  assign mem_read_o   = state_q == LOAD || state_q == RMW_RD;
  assign mem_write_o  = state_q == WRITE;
  assign mem_addr_o   = (mem_read_o || mem_write_o) ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata_o  = mem_write_o ? merged_q : '0;
`ifdef LSU_PERF_CNT_EN
  logic write_q;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      write_q     <= 1'b0;
      load_cnt_o  <= '0;
      store_cnt_o <= '0;
      fault_cnt_o <= '0;
    end else begin
      if (state_q == IDLE && req_valid_i) write_q <= req_write_i;
      if (state_q == RESP) begin
        if (fault_q) fault_cnt_o <= fault_cnt_o + 32'd1;
        else if (write_q) store_cnt_o <= store_cnt_o + 32'd1;
        else load_cnt_o <= load_cnt_o + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven check of load_store_unit against a small word memory.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid_i = 1'b0, req_write_i = 1'b0;
  logic [2:0]  req_funct3_i = '0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic        req_ready_o, resp_valid_o, fault_o, stall_o, mem_read_o, mem_write_o;
  logic [31:0] resp_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [31:0] mem [32];
  int checks = 0, errors = 0;
  int n_load = 0, n_store = 0, n_fault = 0;
  logic [31:0] last_load = '0;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] load_cnt_o, store_cnt_o, fault_cnt_o;
`endif

  load_store_unit #(.MEM_BYTES(120)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .fault_o(fault_o),
    .stall_o(stall_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_rdata_i(mem_rdata_i)
`ifdef LSU_PERF_CNT_EN
    , .load_cnt_o(load_cnt_o), .store_cnt_o(store_cnt_o), .fault_cnt_o(fault_cnt_o)
`endif
  );

  always #5 clk = ~clk;
  assign mem_rdata_i = (mem_addr_o[31:2] < 30) ? mem[mem_addr_o[6:2]] : '0;
  always @(posedge clk) if (mem_write_o) mem[mem_addr_o[6:2]] <= mem_wdata_o;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        flt;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp, input logic flt, input int lat);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp = exp; v.flt = flt; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int cyc, rd, wr, lat;
    logic [31:0] wa, wd;
    string tag;
    tag = $sformatf("v%0d", idx);
    rd = 0; wr = 0; lat = 0; wa = '0; wd = '0;
    @(negedge clk);
    req_valid_i = 1'b1; req_write_i = v.wr; req_funct3_i = v.f3;
    req_addr_i = v.addr; req_wdata_i = v.wdata;
    #1;
    chk({tag, " ready/stall"}, {30'd0, req_ready_o, stall_o}, 32'd3);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    for (cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (mem_read_o) rd++;
      if (mem_write_o) begin wr++; wa = mem_addr_o; wd = mem_wdata_o; end
      if (resp_valid_o) begin lat = cyc; break; end
      chk({tag, " fault outside resp"}, {31'd0, fault_o}, 32'd0);
    end
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " fault"}, {31'd0, fault_o}, {31'd0, v.flt});
    chk({tag, " reads"}, rd, (v.flt || (v.wr && v.f3 == 3'b010)) ? 0 : 1);
    chk({tag, " writes"}, wr, (v.flt || !v.wr) ? 0 : 1);
    if (v.wr && !v.flt) begin
      chk({tag, " write addr"}, wa, v.addr & ~32'd3);
      chk({tag, " write data"}, wd, v.exp);
    end
    if (!v.wr && !v.flt) last_load = v.exp;
    chk({tag, " rdata"}, resp_rdata_o, last_load);
    if (v.flt) n_fault++; else if (v.wr) n_store++; else n_load++;
    @(negedge clk);
    chk({tag, " back idle"}, {30'd0, req_ready_o, resp_valid_o}, 32'd2);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[2]  = 32'h80FF7F01;
    mem[29] = 32'h11223344;
    // loads from word 8 and its extensions
    add(0, 3'b000, 9,   0, 32'h0000007F, 0, 2);
    add(0, 3'b000, 11,  0, 32'hFFFFFF80, 0, 2);
    add(0, 3'b101, 10,  0, 32'h000080FF, 0, 2);
    add(0, 3'b001, 10,  0, 32'hFFFF80FF, 0, 2);
    add(0, 3'b100, 11,  0, 32'h00000080, 0, 2);
    add(0, 3'b010, 8,   0, 32'h80FF7F01, 0, 2);
    // stores: exp holds the merged word that must be written
    add(1, 3'b000, 9,   32'h123456AB, 32'h80FFAB01, 0, 3);
    add(0, 3'b010, 8,   0, 32'h80FFAB01, 0, 2);
    add(1, 3'b001, 10,  32'hCAFE1234, 32'h1234AB01, 0, 3);
    add(0, 3'b010, 8,   0, 32'h1234AB01, 0, 2);
    add(1, 3'b010, 4,   32'hDEADBEEF, 32'hDEADBEEF, 0, 2);
    add(0, 3'b101, 6,   0, 32'h0000DEAD, 0, 2);
    add(0, 3'b001, 6,   0, 32'hFFFFDEAD, 0, 2);
    add(0, 3'b000, 4,   0, 32'hFFFFFFEF, 0, 2);
    // faults and range edges
    add(0, 3'b010, 6,   0, 0, 1, 1);
    add(0, 3'b010, 116, 0, 32'h11223344, 0, 2);
    add(0, 3'b010, 120, 0, 0, 1, 1);
    add(0, 3'b001, 9,   0, 0, 1, 1);
    add(0, 3'b011, 8,   0, 0, 1, 1);
    add(1, 3'b100, 8,   32'h1, 0, 1, 1);
    add(0, 3'b000, 117, 0, 32'h00000033, 0, 2);
    add(1, 3'b000, 121, 32'h55, 0, 1, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", {31'd0, req_ready_o}, 32'd1);
    chk("reset outs", {26'd0, resp_valid_o, fault_o, stall_o, mem_read_o, mem_write_o, 1'b0}, 32'd0);
    chk("reset rdata", resp_rdata_o, 32'd0);
    chk("reset addr/wdata", mem_addr_o | mem_wdata_o, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run(vecs[i], i);

`ifdef LSU_PERF_CNT_EN
    chk("load_cnt", load_cnt_o, n_load);
    chk("store_cnt", store_cnt_o, n_store);
    chk("fault_cnt", fault_cnt_o, n_fault);
`endif

    // SH accepted, then reset during RMW_RD must abort with no write or response
    begin
      int bad;
      bad = 0;
      @(negedge clk);
      req_valid_i = 1'b1; req_write_i = 1'b1; req_funct3_i = 3'b001;
      req_addr_i = 2; req_wdata_i = 32'h0000BEEF;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      @(negedge clk);
      chk("abort in rmw read", {31'd0, mem_read_o}, 32'd1);
      #2 rst_n = 1'b1;
      #1 chk("abort async ready", {31'd0, req_ready_o}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (mem_write_o || resp_valid_o) bad++;
      end
      chk("abort no write/resp", bad, 0);
      chk("abort ready", {31'd0, req_ready_o}, 32'd1);
      chk("abort mem intact", mem[0], 32'd0);
`ifdef LSU_PERF_CNT_EN
      chk("cnt reset", load_cnt_o | store_cnt_o | fault_cnt_o, 32'd0);
`endif
    end
    last_load = '0;
    n_load = 0; n_store = 0; n_fault = 0;
    run('{wr: 1'b0, f3: 3'b010, addr: 32'd4, wdata: 32'd0, exp: 32'hDEADBEEF, flt: 1'b0, lat: 2}, 99);
`ifdef LSU_PERF_CNT_EN
    chk("load_cnt after reset", load_cnt_o, 32'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage access controller between the EX/MEM pipeline register and the byte-addressed, word-wide data memory.
- Converts RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned memory accesses.
- Performs sign/zero extension on loads and read-modify-write for sub-word stores.
- Flags misaligned, out-of-range and illegal requests, and stalls the pipeline while busy.

Parameters:
- MEM_BYTES, 120, data memory size in bytes; a word address whose last byte is at or beyond MEM_BYTES is a fault.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-high
- req_valid_i  input  1  request from MEM stage
- req_ready_o  output  1  request accepted this cycle when high with req_valid_i
- req_write_i  input  1  1 = store, 0 = load
- req_funct3_i  input  3  RV32I funct3 width/sign code
- req_addr_i  input  32  byte address
- req_wdata_i  input  32  store data, right-aligned
- resp_valid_o  output  1  one-cycle completion pulse
- resp_rdata_o  output  32  extended load data
- fault_o  output  1  valid with resp_valid_o: misaligned, out-of-range or illegal funct3
- stall_o  output  1  pipeline hold
- mem_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata_o  output  32  merged word to write
- mem_read_o  output  1  memory read enable
- mem_write_o  output  1  memory write enable, one cycle per store
- mem_rdata_i  input  32  combinational read data from memory

Behaviour:
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Reset values (async): state IDLE; all outputs 0 except req_ready_o = 1; latched request cleared.
- IDLE:
  - req_ready_o = 1, stall_o = 0.
  - On req_valid_i, latch addr, funct3, write and wdata.
  - Fault request -> RESP with fault latched.
  - Load -> LOAD; SW -> WRITE with merged = wdata; SB/SH -> RMW_RD.
- Fault conditions:
  - funct3 not in {000,001,010,100,101} for loads, or not in {000,001,010} for stores.
  - Halfword with addr[0] = 1; word with addr[1:0] != 0.
  - Word address + 3 >= MEM_BYTES.
- No memory enable is ever asserted for a faulting request.
- LOAD:
  - mem_read_o = 1.
  - At the clock edge, select byte/half by addr[1:0] / addr[1], then sign-extend (000/001) or zero-extend (100/101); LW passes the word.
  - Register result, go to RESP.
- RMW_RD:
  - mem_read_o = 1.
  - Merge wdata[7:0] into byte lane addr[1:0] (SB) or wdata[15:0] into half lane addr[1] (SH); other lanes come from mem_rdata_i.
  - Go to WRITE.
- WRITE: mem_write_o = 1, mem_wdata_o = merged; go to RESP.
- RESP:
  - resp_valid_o = 1 for exactly one cycle, fault_o as latched; go to IDLE.
  - No new request is accepted in RESP.
- Outside RESP: fault_o = 0. resp_rdata_o holds the last load value until the next load completes; stores and faults leave it unchanged.
- stall_o = (state != IDLE) | (req_valid_i in IDLE).
- Latency, acceptance edge to resp_valid_o cycle: fault 1, load 2, SW 2, SB/SH 3.
- mem_addr_o is driven only in LOAD/RMW_RD/WRITE; 0 otherwise. mem_wdata_o is 0 outside WRITE.
- Reset asserted mid-operation aborts immediately: no pending write is issued, no response pulse.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- When defined, add outputs load_cnt_o, store_cnt_o and fault_cnt_o (32 bits each). Each increments on resp_valid_o for a non-faulting load, a non-faulting store, or a fault respectively. Counters wrap at 2^32 and reset to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Memory word at 8 = 0x80FF7F01; LB addr 9 -> resp_rdata_o 0x0000007F after 2 cycles, fault_o 0, one mem_read cycle.
- Same word; LB addr 11 -> 0xFFFFFF80; LHU addr 10 -> 0x000080FF; LH addr 10 -> 0xFFFF80FF.
- Same word; SB wdata 0x123456AB addr 9 -> exactly one mem_write_o cycle with mem_addr_o 8 and mem_wdata_o 0x80FFAB01; resp_valid_o 3 cycles after acceptance.
- LW addr 6 -> fault_o 1 with resp_valid_o next cycle, mem_read_o/mem_write_o never asserted.
- LW addr 116 -> ok; LW addr 120 -> fault.
- SH addr 2 accepted, rst_n pulsed during RMW_RD -> no mem_write_o, no resp_valid_o, req_ready_o 1 after reset. With LSU_PERF_CNT_EN defined, counters read 0 after reset.
